// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the fft_8_rad2 core.
// Buffers one serial frame and feeds it to the core as (x[k], x[k+N/2]) pairs.
// Captures the core's parallel result and streams the bins out serially.
// Optional feature macro: FFT_CTRL_TIMEOUT_EN. When it is defined, a frame is dropped if the
// core result does not arrive within FLUSH_MAX WAIT cycles, and timeout_err is set.

package fft_frame_ctrl_pkg;
    typedef struct packed {
        logic signed [15:0] r;
        logic signed [15:0] i;
    } complex_product_t;
endpackage

module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned FLUSH_MAX = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  complex_product_t         in_data,
    output logic                     fft_enable,
    output complex_product_t         fft_data_0,
    output complex_product_t         fft_data_1,
    input  complex_product_t [N-1:0] fft_out,
    input  logic                     fft_out_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output complex_product_t         out_data,
    output logic [$clog2(N)-1:0]     out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned IdxW  = $clog2(N);
    localparam int unsigned HalfW = $clog2(N / 2);

    typedef enum logic [1:0] {
        StFill,
        StFeed,
        StWait,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [IdxW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [IdxW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [HalfW-1:0] k_q, k_d;

    logic mem_we;
    logic cap_we;

    complex_product_t mem_q [N];
    complex_product_t cap_q [N];

    // Registered output images
    logic             in_ready_q, in_ready_d;
    logic             fft_enable_q, fft_enable_d;
    complex_product_t fft_data_0_q, fft_data_0_d;
    complex_product_t fft_data_1_q, fft_data_1_d;
    logic             out_valid_q, out_valid_d;
    complex_product_t out_data_q, out_data_d;
    logic [IdxW-1:0]  out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int unsigned WcW = $clog2(FLUSH_MAX + 1);

    logic [WcW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_set;
    logic           timeout_err_q;
`else
    // No WAIT limit in this build; FLUSH_MAX is only referenced to keep it visibly consumed.
    logic unused_flush_max;
    assign unused_flush_max = ^FLUSH_MAX;
`endif

    // Next-state logic: frame sequencing and counter advance.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        k_d      = k_q;
        mem_we   = 1'b0;
        cap_we   = 1'b0;
`ifdef FFT_CTRL_TIMEOUT_EN
        wait_cnt_d  = '0;
        timeout_set = 1'b0;
`endif
        unique case (state_q)
            StFill: begin
                if (in_valid && in_ready_q) begin
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + IdxW'(1);
                    if (wr_cnt_q == IdxW'(N - 1)) begin
                        state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                // k wraps to 0 naturally because N/2 is a power of two.
                k_d = k_q + HalfW'(1);
                if (k_q == HalfW'(N / 2 - 1)) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (fft_out_valid) begin
                    cap_we  = 1'b1;
                    state_d = StDrain;
                end
`ifdef FFT_CTRL_TIMEOUT_EN
                else if (wait_cnt_q == WcW'(FLUSH_MAX - 1)) begin
                    // Drop the frame: no DRAIN, straight back to FILL.
                    state_d     = StFill;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WcW'(1);
                end
`endif
            end
            StDrain: begin
                if (out_ready) begin
                    rd_cnt_d = rd_cnt_q + IdxW'(1);
                    if (rd_cnt_q == IdxW'(N - 1)) begin
                        state_d = StFill;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    // Output images derived from the next state so the registered outputs align with state_q.
    always_comb begin
        in_ready_d   = (state_d == StFill);
        fft_enable_d = (state_d == StFeed) || (state_d == StWait);
        fft_data_0_d = '0;
        fft_data_1_d = '0;
        out_valid_d  = (state_d == StDrain);
        out_data_d   = '0;
        out_idx_d    = '0;
        out_last_d   = 1'b0;
        busy_d       = (state_d != StFill) || (wr_cnt_d != '0);
        if (state_d == StFeed) begin
            // Beat N-1 lands in the upper half at k=N/2-1, never at k=0, so mem_q is current.
            fft_data_0_d = mem_q[{1'b0, k_d}];
            fft_data_1_d = mem_q[{1'b1, k_d}];
        end
        if (state_d == StDrain) begin
            out_data_d = cap_we ? fft_out[rd_cnt_d] : cap_q[rd_cnt_d];
            out_idx_d  = rd_cnt_d;
            out_last_d = (rd_cnt_d == IdxW'(N - 1));
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFill;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            k_q          <= '0;
            in_ready_q   <= 1'b0;
            fft_enable_q <= 1'b0;
            fft_data_0_q <= '0;
            fft_data_1_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            k_q          <= k_d;
            in_ready_q   <= in_ready_d;
            fft_enable_q <= fft_enable_d;
            fft_data_0_q <= fft_data_0_d;
            fft_data_1_q <= fft_data_1_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
        end
    end

    // Sample buffer and capture buffer; data is never exposed except through the FSM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_cnt_q] <= in_data;
        end
        if (cap_we) begin
            for (int j = 0; j < N; j++) begin
                cap_q[j] <= fft_out[j];
            end
        end
    end

`ifdef FFT_CTRL_TIMEOUT_EN
    // WAIT watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_q | timeout_set;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign in_ready   = in_ready_q;
    assign fft_enable = fft_enable_q;
    assign fft_data_0 = fft_data_0_q;
    assign fft_data_1 = fft_data_1_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;

endmodule
